// File: rtl/conv_window_gen.sv
// Sliding SIZE x SIZE window generator: raster pixel stream in, fully-valid
// ("valid" convolution) windows out, backed by SIZE-1 line buffers.
module conv_window_gen #(
    parameter int SIZE      = 3,
    parameter int WIDTH_BIT = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic                                          clock,
    input  logic                                          nreset,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    input  logic signed [WIDTH_BIT-1:0]                   pix_data,
    output logic                                          win_valid,
    input  logic                                          win_ready,
    output logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_data,
    output logic                                          frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {LOAD, RUN} state_t;

    state_t                                   state_q, state_d;
    logic [CW-1:0]                            col_q, col_d;
    logic [RW-1:0]                            row_q, row_d;
    // lb_q[0] holds the oldest row, lb_q[SIZE-2] the row just above the current one
    logic [WIDTH_BIT-1:0]                     lb_q [SIZE-1][IMG_W];
    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] sh_q, sh_d;
    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_q;
    logic                                     win_valid_q, win_valid_d;
    logic                                     frame_done_q, frame_done_d;
    logic                                     pix_acc, win_acc, col_last, row_last, emit;

    assign pix_ready = !win_valid_q || win_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign win_acc   = win_valid_q && win_ready;
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_acc) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shift window left; new right column is the line-buffer column plus the incoming pixel
    always_comb begin
        sh_d = sh_q;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE - 1; c++) begin
                sh_d[r][c] = sh_q[r][c+1];
            end
        end
        for (int r = 0; r < SIZE - 1; r++) begin
            sh_d[r][SIZE-1] = lb_q[r][col_q];
        end
        sh_d[SIZE-1][SIZE-1] = pix_data;
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: if (pix_acc && col_last && row_q == RW'(SIZE - 2)) state_d = RUN;
            RUN:  if (pix_acc && col_last && row_last)              state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // In RUN the row is always >= SIZE-1, so only the column gates emission
    always_comb begin
        emit         = pix_acc && (state_q == RUN) && (col_q >= CW'(SIZE - 1));
        frame_done_d = pix_acc && (state_q == RUN) && col_last && row_last;
        if (emit) begin
            win_valid_d = 1'b1;
        end else if (win_acc) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            col_q        <= '0;
            row_q        <= '0;
            sh_q         <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (pix_acc) sh_q  <= sh_d;
            if (emit)    win_q <= sh_d;
        end
    end

    always_ff @(posedge clock) begin
        if (pix_acc && !nreset) begin
            for (int i = 0; i < SIZE - 2; i++) begin
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            end
            lb_q[SIZE-2][col_q] <= pix_data;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x5 frame with a 3x3 window.
module tb_conv_window_gen;

    localparam int SZ = 3;
    localparam int WB = 8;
    localparam int IW = 5;
    localparam int IH = 5;

    logic                              clock = 1'b0;
    logic                              nreset = 1'b1;
    logic                              pix_valid = 1'b0;
    logic                              pix_ready;
    logic signed [WB-1:0]              pix_data = '0;
    logic                              win_valid;
    logic                              win_ready = 1'b1;
    logic signed [SZ-1:0][SZ-1:0][WB-1:0] win_data;
    logic                              frame_done;
    logic [71:0]                       wd;

    int          n_chk = 0;
    int          n_fail = 0;
    int          fd_cnt = 0;
    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];
    int          frm[IW*IH];
    int          fr2[2*IW*IH];

    assign wd = win_data;

    always #5 clock = ~clock;

    conv_window_gen #(.SIZE(SZ), .WIDTH_BIT(WB), .IMG_W(IW), .IMG_H(IH)) dut (
        .clock(clock), .nreset(nreset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .frame_done(frame_done)
    );

    always @(negedge clock) begin
        if (win_valid && win_ready) got_q.push_back(wd);
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [SZ-1:0][SZ-1:0][WB-1:0] w;
        for (int i = 0; i < SZ; i++)
            for (int j = 0; j < SZ; j++)
                w[i][j] = 8'(frm[(r+i)*IW + c + j]);
        return w;
    endfunction

    function automatic logic [71:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic send(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(frm[k]);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        nreset = 1'b0;
        chk("rst_wvalid", win_valid, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_wdata", wd, 0);
        chk("rst_pready", pix_ready, 1);

        // basic frame, latency, row boundary, frame_done
        for (int k = 0; k < IW*IH; k++) frm[k] = k;
        got_q.delete();
        fd_cnt = 0;
        for (int k = 0; k < IW*IH; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(k);
            tick();
            if (k == 11) chk("lat_pre", win_valid, 0);
            if (k == 12) begin
                chk("lat_first", win_valid, 1);
                chk("win_first", wd, {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
            end
            if (k == 15) chk("rowb_15", win_valid, 0);
            if (k == 16) chk("rowb_16", win_valid, 0);
            if (k == 23) chk("fd_early", frame_done, 0);
            if (k == 24) begin
                chk("fd_pulse", frame_done, 1);
                chk("fd_with_win", win_valid, 1);
                chk("win_last", wd, {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12});
            end
        end
        pix_valid = 1'b0;
        tick();
        chk("fd_one_cycle", frame_done, 0);
        tick();
        chk("basic_count", got_q.size(), 9);
        chk("rowb_before", got_at(2), {8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7, 8'd4, 8'd3, 8'd2});
        chk("rowb_after", got_at(3), {8'd17, 8'd16, 8'd15, 8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5});
        chk("basic_fd_cnt", fd_cnt, 1);

        // backpressure on the first window
        got_q.delete();
        send(0, 12);
        chk("bp_valid", win_valid, 1);
        win_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'sd13;
        for (int h = 0; h < 4; h++) begin
            #1;
            chk("bp_pready", pix_ready, 0);
            tick();
            chk("bp_hold", wd, {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
        end
        win_ready = 1'b1;
        tick();
        chk("bp_next_valid", win_valid, 1);
        chk("bp_next", wd, {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1});
        send(14, 24);
        tick();
        tick();
        chk("bp_count", got_q.size(), 9);
        chk("bp_got0", got_at(0), exp_win(0, 0));
        chk("bp_got1", got_at(1), exp_win(0, 1));

        // signed extremes pass through untouched
        frm[11] = 127;
        frm[12] = -128;
        send(0, 12);
        chk("sgn_22", win_data[2][2], 8'h80);
        chk("sgn_21", win_data[2][1], 8'h7f);
        send(13, 24);
        tick();
        tick();

        // reset mid-frame
        for (int k = 0; k < IW*IH; k++) frm[k] = k;
        send(0, 17);
        nreset = 1'b1;
        tick();
        nreset = 1'b0;
        chk("mrst_wvalid", win_valid, 0);
        chk("mrst_fdone", frame_done, 0);
        got_q.delete();
        fd_cnt = 0;
        for (int k = 0; k < IW*IH; k++) frm[k] = 100 + k;
        send(0, 24);
        tick();
        tick();
        chk("mrst_count", got_q.size(), 9);
        chk("mrst_first", got_at(0), {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100});
        chk("mrst_last", got_at(8), exp_win(2, 2));
        chk("mrst_fd_cnt", fd_cnt, 1);

        // back-to-back random frames with random gaps and backpressure
        for (int k = 0; k < 2*IW*IH; k++) fr2[k] = int'($urandom_range(0, 255));
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < IW*IH; k++) frm[k] = fr2[f*IW*IH + k];
            for (int r = 0; r <= IH - SZ; r++)
                for (int c = 0; c <= IW - SZ; c++)
                    exp_q.push_back(exp_win(r, c));
        end
        got_q.delete();
        fd_cnt = 0;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 2*IW*IH && cyc < 3000) begin
                pix_valid = ($urandom % 4) != 0;
                pix_data  = 8'(fr2[k]);
                win_ready = ($urandom % 3) != 0;
                @(negedge clock);
                if (pix_valid && pix_ready) k++;
                tick();
                cyc++;
            end
            chk("rnd_all_sent", k, 2*IW*IH);
        end
        pix_valid = 1'b0;
        win_ready = 1'b1;
        repeat (4) tick();
        chk("rnd_count", got_q.size(), 18);
        chk("rnd_fd_cnt", fd_cnt, 2);
        for (int i = 0; i < 18; i++) chk($sformatf("rnd_win%0d", i), got_at(i), exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
